mem_arbiter: RTL

//  Shares the single-port program/data memory between the control unit's instruction

---
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between N_REQ requesters.
// One access in flight at a time: grant, issue, wait out the memory latency, acknowledge.
module mem_arbiter #(
    parameter int N_REQ   = 3,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        ack,
    output logic [DATA_W-1:0]       rdata,
    output logic                    busy,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata
);

    // state | meaning
    // IDLE  | arbitrating; also the ack cycle of the previous access
    // ISSUE | mem_en asserted with the latched command
    // WAIT  | memory latency beyond the first cycle (skipped when MEM_LAT=1)
    // DONE  | mem_rdata valid; capture and acknowledge at the edge
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int PTR_W = $clog2(N_REQ);
    localparam int PW1   = PTR_W + 1;
    localparam int CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
    localparam logic [PW1-1:0]   N_REQ_W  = PW1'(N_REQ);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

    if (N_REQ < 2 || N_REQ > 4) begin : g_bad_n_req
        $error("mem_arbiter: N_REQ must be in 2..4");
    end
    if (MEM_LAT < 1) begin : g_bad_mem_lat
        $error("mem_arbiter: MEM_LAT must be >= 1");
    end

    logic [1:0]        state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [ADDR_W-1:0] addr_arr  [N_REQ];
    logic [DATA_W-1:0] wdata_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end

    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [PW1-1:0]   cand;
    logic [PW1-1:0]   rr_next;

    // Scan downward from the farthest offset so the closest requester to rr_ptr wins last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + PW1'(k);
            if (cand >= N_REQ_W) begin
                cand = cand - N_REQ_W;
            end
            if (req[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
        rr_next = {1'b0, win_idx} + PW1'(1);
        if (rr_next == N_REQ_W) begin
            rr_next = '0;
        end
    end

    always_comb begin
        gnt = '0;
        if (reset && state_q == S_IDLE && win_found) begin
            gnt[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        ack_d    = '0;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d  = S_ISSUE;
                    owner_d  = win_idx;
                    we_d     = req_we[win_idx];
                    addr_d   = addr_arr[win_idx];
                    wdata_d  = wdata_arr[win_idx];
                    rr_ptr_d = rr_next[PTR_W-1:0];
                end
            end
            S_ISSUE: begin
                if (MEM_LAT == 1) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                ack_d[owner_q] = 1'b1;
                if (!we_q) begin
                    rdata_d = mem_rdata;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            ack_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
        end
    end

    // Strobes decode the registered state so an async reset drops them at once.
    assign busy      = (state_q != S_IDLE);
    assign mem_en    = (state_q == S_ISSUE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;

endmodule
